// File: rtl/qspi_fifo_pkg.sv
// Shared constants and sizing helpers for the QSPI RX/TX word FIFOs.
package qspi_fifo_pkg;

    localparam int BYTE_W = 8;

    // Number of byte lanes in a word of the given width.
    function automatic int lane_count(input int width);
        return width / BYTE_W;
    endfunction

    // Width of a byte-count field able to hold 0..lane_count(width).
    function automatic int cnt_width(input int width);
        return $clog2(width / BYTE_W + 1);
    endfunction

endpackage

// File: rtl/rx_byte_packer.sv
// Collects received bytes LSB-first into words and emits a push strobe when
// a word completes or a partial word is flushed at end of transfer.
//
// Handshake: push_o is a single-cycle strobe with no back-pressure. The
// consumer either stores the word or drops it; the packer always starts a
// fresh word on the cycle after push_o, whichever happened.
module rx_byte_packer
    import qspi_fifo_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int LANES = lane_count(WIDTH),
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             wr_en_i,
    input  logic [7:0]       wr_byte_i,
    input  logic             flush_i,
    output logic             push_o,
    output logic [WIDTH-1:0] push_word_o,
    output logic [CW-1:0]    push_bytes_o
);

    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_with;
    logic [CW-1:0]    cnt_with;

    // Merge this cycle's byte into the buffered lanes and decide whether to push.
    always_comb begin
        word_with = word_q;
        if (wr_en_i) begin
            word_with = word_q | (WIDTH'(wr_byte_i) << {cnt_q, 3'b000});
        end
        cnt_with     = cnt_q + CW'(wr_en_i);
        push_o       = (cnt_with == CW'(LANES)) || (flush_i && (cnt_with != '0));
        push_word_o  = word_with;
        push_bytes_o = cnt_with;
        if (clear_i || push_o) begin
            word_d = '0;
            cnt_d  = '0;
        end else begin
            word_d = word_with;
            cnt_d  = cnt_with;
        end
    end

    // Packer state; reset discards any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_pack_fifo.sv
// RX word FIFO: byte packer in front of a DEPTH-entry word store with
// level/watermark status and sticky overflow/underflow flags.
module rx_pack_fifo
    import qspi_fifo_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    parameter  int FWFT  = 1,
    localparam int BW    = cnt_width(WIDTH),
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             wr_en_i,
    input  logic [7:0]       wr_byte_i,
    input  logic             pack_flush_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [BW-1:0]    rd_bytes_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o,
    input  logic [LW-1:0]    wm_thresh_i,
    output logic             wm_o,
    output logic             ovf_o,
    output logic             udf_o,
    input  logic             err_clr_i
);

    logic             pk_push;
    logic [WIDTH-1:0] pk_word;
    logic [BW-1:0]    pk_bytes;

    logic [WIDTH-1:0] mem_data  [DEPTH];
    logic [BW-1:0]    mem_bytes [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          push_ok, pop_ok, ovf_set, udf_set;

    rx_byte_packer #(.WIDTH(WIDTH)) u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear_i),
        .wr_en_i      (wr_en_i),
        .wr_byte_i    (wr_byte_i),
        .flush_i      (pack_flush_i),
        .push_o       (pk_push),
        .push_word_o  (pk_word),
        .push_bytes_o (pk_bytes)
    );

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == LW'(DEPTH));
    assign level_o = count_q;
    assign wm_o    = (wm_thresh_i != '0) && (count_q >= wm_thresh_i);
    assign ovf_o   = ovf_q;
    assign udf_o   = udf_q;

    // Accept/pop decisions; a pop on a full FIFO frees the slot for a same-cycle push.
    always_comb begin
        pop_ok   = rd_en_i && !empty_o && !clear_i;
        push_ok  = pk_push && !clear_i && (!full_o || pop_ok);
        ovf_set  = pk_push && !clear_i && !push_ok;
        udf_set  = rd_en_i && empty_o && !clear_i;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + LW'(push_ok) - LW'(pop_ok);
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        ovf_d = ovf_set || (ovf_q && !err_clr_i);
        udf_d = udf_set || (udf_q && !err_clr_i);
    end

    // Pointers, count and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Word storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr_q]  <= pk_word;
            mem_bytes[wr_ptr_q] <= pk_bytes;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry falls through combinationally; zero while empty.
            always_comb begin
                rd_data_o  = '0;
                rd_bytes_o = '0;
                if (!empty_o) begin
                    rd_data_o  = mem_data[rd_ptr_q];
                    rd_bytes_o = mem_bytes[rd_ptr_q];
                end
            end
        end else begin : g_reg
            logic [WIDTH-1:0] rd_data_q;
            logic [BW-1:0]    rd_bytes_q;

            // Capture the popped entry; hold otherwise.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_data_q  <= '0;
                    rd_bytes_q <= '0;
                end else if (clear_i) begin
                    rd_data_q  <= '0;
                    rd_bytes_q <= '0;
                end else if (pop_ok) begin
                    rd_data_q  <= mem_data[rd_ptr_q];
                    rd_bytes_q <= mem_bytes[rd_ptr_q];
                end
            end

            assign rd_data_o  = rd_data_q;
            assign rd_bytes_o = rd_bytes_q;
        end
    endgenerate

endmodule
